serial_compare_accumulator: RTL and testbench
=============================================

# serial_compare_accumulator

Downstream of the 2-bit comparator stage. Each cycle it accepts one digit-compare result (f1 = A>B, f2 = A==B, f3 = A<B) for a 2-bit digit pair, most significant digit first. It folds these into a registered magnitude verdict for operands of up to MAX_DIGITS digits. It also flags malformed result codes and over-long operands.

## Interface
- MAX_DIGITS, 8, maximum digits per operand (≥1); CW = $clog2(MAX_DIGITS+1)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- digit_valid  input  1  f1/f2/f3 carry a digit result this cycle
- first  input  1  qualifies digit_valid: this digit is the MSB; starts a new comparison
- last  input  1  qualifies digit_valid: this digit is the LSB; ends the comparison
- f1  input  1  digit A>B
- f2  input  1  digit A==B
- f3  input  1  digit A<B
- gt  output  1  operand A > B (valid while done_hold)
- eq  output  1  operand A == B
- lt  output  1  operand A < B
- done  output  1  one-cycle pulse: verdict just became valid
- busy  output  1  comparison in progress
- err  output  1  sticky error for the current or last comparison
- digit_cnt  output  CW  digits accepted in the current or last comparison

## Operation
- Digit accepted = digit_valid && (first || state ∉ {IDLE, DONE}).
- Code check: exactly one of f1/f2/f3 high. Otherwise the digit is malformed: err := 1, and the digit is treated as equal.
- States:
  - IDLE (reset).
  - EQ_RUN: all digits so far equal.
  - GT_LOCK.
  - LT_LOCK.
  - DONE: verdict held.
- Transitions on an accepted digit:
  - first clears err and sets digit_cnt := 1, else digit_cnt += 1.
  - From EQ_RUN or start: f1 → GT_LOCK, f3 → LT_LOCK, f2 → EQ_RUN.
  - GT_LOCK/LT_LOCK ignore later digit values; digit_cnt still increments.
  - last → DONE from any running state. gt/eq/lt take the locked verdict, or eq=1 if still EQ_RUN.
- first while running: abort silently with no done; restart with this digit.
- first && last: single-digit compare; DONE next cycle.
- digit_valid without first in IDLE/DONE: ignored; no state or count change.
- Overflow: an accepted digit that would make digit_cnt exceed MAX_DIGITS:
  - err := 1, force DONE with eq=gt=lt=0, done pulses.
  - digit_cnt saturates at MAX_DIGITS.
- DONE holds gt/eq/lt/err/digit_cnt until the next accepted first.
- Outputs gt/eq/lt are mutually exclusive. All zero except in DONE.

## Timing
- Reset values: state=IDLE, gt=eq=lt=0, done=0, busy=0, err=0, digit_cnt=0.
- rst mid-comparison returns to these values on the next edge; no done pulse.
- All outputs are registered. Latency from accepted last digit to done/gt/eq/lt: 1 cycle.
- done is high for exactly one cycle, in the first cycle of DONE.
- busy = state ∈ {EQ_RUN, GT_LOCK, LT_LOCK}. It rises the cycle after an accepted first without last.
- Back-to-back operation: first may arrive in the cycle DONE is entered. New comparison throughput is one digit per cycle with no bubbles.
- digit_valid low mid-comparison stalls; state and digit_cnt are held indefinitely.

## Structure
- Shared package cmp_pkg:
  - state enum (IDLE, EQ_RUN, GT_LOCK, LT_LOCK, DONE).
  - verdict encoding constants (VERDICT_GT, VERDICT_EQ, VERDICT_LT, VERDICT_NONE).
- Sub-module cmp_code_decode (combinational): maps f1/f2/f3 to {digit_gt, digit_lt, malformed}. Reused wherever comparator outputs are consumed.
- Top: FSM, digit counter, verdict/err registers.

## Test plan
- 4 digits, A=8'b10_01_11_00 vs B=8'b10_01_10_11 (codes eq,eq,gt,lt), last on digit 4 → done 1 cycle after, gt=1, digit_cnt=4, err=0.
- 3 digits, all f2 → eq=1 held through 5 idle cycles. A following first with an f3 digit clears eq; busy=1 on the next cycle.
- first && last, f3=1 → next cycle done=1, lt=1, digit_cnt=1, busy never high.
- Digit 2 arrives with f1=f3=1 → err=1, comparison continues as equal. Final verdict from later digits; err still 1 at done.
- MAX_DIGITS=8, 9 digits without last → on digit 9: done=1, err=1, gt=eq=lt=0, digit_cnt=8.
- rst asserted after digit 2 of 4 → all outputs 0 next cycle. Later digit_valid without first is ignored; no done.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial digit-compare accumulator.
// Holds the FSM state encoding, verdict codes and the result-code check.
package cmp_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EQ_RUN  = 3'd1,
        GT_LOCK = 3'd2,
        LT_LOCK = 3'd3,
        DONE    = 3'd4
    } cmp_state_t;

    localparam logic [1:0] VERDICT_NONE = 2'd0;
    localparam logic [1:0] VERDICT_GT   = 2'd1;
    localparam logic [1:0] VERDICT_EQ   = 2'd2;
    localparam logic [1:0] VERDICT_LT   = 2'd3;

    // A comparator result code is well formed only when exactly one flag is high.
    function automatic logic code_onehot(input logic [2:0] code);
        return (code == 3'b001) || (code == 3'b010) || (code == 3'b100);
    endfunction

endpackage

// File: rtl/cmp_code_decode.sv
// Decodes one {A>B, A==B, A<B} comparator result into usable digit flags.
// Malformed codes report neither greater nor less, so they fold as "equal".
module cmp_code_decode
    import cmp_pkg::*;
(
    input  logic f1,
    input  logic f2,
    input  logic f3,
    output logic digit_gt,
    output logic digit_lt,
    output logic malformed
);

    logic valid_code_s;

    assign valid_code_s = code_onehot({f1, f2, f3});
    assign malformed    = ~valid_code_s;
    assign digit_gt     = valid_code_s & f1;
    assign digit_lt     = valid_code_s & f3;

endmodule

// File: rtl/serial_compare_accumulator.sv
// Folds MSB-first digit compare results into a registered magnitude verdict,
// with a sticky error for malformed codes and operands longer than MAX_DIGITS.
module serial_compare_accumulator
    import cmp_pkg::*;
#(
    parameter  int MAX_DIGITS = 8,
    localparam int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          digit_valid,
    input  logic          first,
    input  logic          last,
    input  logic          f1,
    input  logic          f2,
    input  logic          f3,
    output logic          gt,
    output logic          eq,
    output logic          lt,
    output logic          done,
    output logic          busy,
    output logic          err,
    output logic [CW-1:0] digit_cnt
);

    localparam logic [CW:0] MAX_CNT = (CW + 1)'(MAX_DIGITS);

    cmp_state_t    state_q, state_d;
    cmp_state_t    base_state_s, lock_state_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   cnt_inc_s;
    logic [1:0]    verdict_s;
    logic          gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic          done_q, done_d, busy_q, busy_d, err_q, err_d;
    logic          running_s, accept_s;
    logic          digit_gt_s, digit_lt_s, malformed_s;

    cmp_code_decode u_decode (
        .f1        (f1),
        .f2        (f2),
        .f3        (f3),
        .digit_gt  (digit_gt_s),
        .digit_lt  (digit_lt_s),
        .malformed (malformed_s)
    );

    assign running_s = (state_q == EQ_RUN) || (state_q == GT_LOCK) || (state_q == LT_LOCK);
    assign accept_s  = digit_valid && (first || running_s);
    // A first digit restarts from an all-equal history regardless of the current state.
    assign base_state_s = first ? EQ_RUN : state_q;
    assign cnt_inc_s    = (first ? {(CW + 1){1'b0}} : {1'b0, cnt_q}) + {{CW{1'b0}}, 1'b1};

    // Next state, counter, error and verdict for the accepted digit.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        gt_d         = gt_q;
        eq_d         = eq_q;
        lt_d         = lt_q;
        done_d       = 1'b0;
        lock_state_s = base_state_s;
        verdict_s    = VERDICT_NONE;
        case (base_state_s)
            EQ_RUN:  lock_state_s = digit_gt_s ? GT_LOCK : (digit_lt_s ? LT_LOCK : EQ_RUN);
            GT_LOCK: lock_state_s = GT_LOCK;
            LT_LOCK: lock_state_s = LT_LOCK;
            default: lock_state_s = EQ_RUN;
        endcase
        case (lock_state_s)
            GT_LOCK: verdict_s = VERDICT_GT;
            LT_LOCK: verdict_s = VERDICT_LT;
            EQ_RUN:  verdict_s = VERDICT_EQ;
            default: verdict_s = VERDICT_NONE;
        endcase
        if (accept_s) begin
            gt_d = 1'b0;
            eq_d = 1'b0;
            lt_d = 1'b0;
            if (cnt_inc_s > MAX_CNT) begin
                state_d = DONE;
                cnt_d   = MAX_CNT[CW-1:0];
                err_d   = 1'b1;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_inc_s[CW-1:0];
                err_d = (first ? 1'b0 : err_q) | malformed_s;
                if (last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    gt_d    = (verdict_s == VERDICT_GT);
                    eq_d    = (verdict_s == VERDICT_EQ);
                    lt_d    = (verdict_s == VERDICT_LT);
                end else begin
                    state_d = lock_state_s;
                end
            end
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d == EQ_RUN) || (state_d == GT_LOCK) || (state_d == LT_LOCK);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            err_q   <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_serial_compare_accumulator.sv
// Table-driven bench: each row drives one cycle of inputs and queues the
// outputs expected after that clock edge; they are popped and compared there.
module tb_serial_compare_accumulator;

    localparam logic [2:0] C_GT  = 3'b100;
    localparam logic [2:0] C_EQ  = 3'b010;
    localparam logic [2:0] C_LT  = 3'b001;
    localparam logic [2:0] C_BAD = 3'b101;
    localparam logic [2:0] C_NIL = 3'b000;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic       fs;
        logic       ls;
        logic [2:0] f;
        logic [9:0] exp;  // {gt, eq, lt, done, busy, err, cnt[3:0]}
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, digit_valid, first, last, f1, f2, f3;
    logic       gt, eq, lt, done, busy, err;
    logic [3:0] digit_cnt;

    vec_t       vecs[$];
    logic [9:0] exp_q[$];
    int         checks   = 0;
    int         failures = 0;

    serial_compare_accumulator #(.MAX_DIGITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .first       (first),
        .last        (last),
        .f1          (f1),
        .f2          (f2),
        .f3          (f3),
        .gt          (gt),
        .eq          (eq),
        .lt          (lt),
        .done        (done),
        .busy        (busy),
        .err         (err),
        .digit_cnt   (digit_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic fs, input logic ls,
                                input logic [2:0] f, input logic g, input logic e, input logic l,
                                input logic d, input logic b, input logic er, input logic [3:0] c);
        vec_t t;
        t.rst = r; t.v = v; t.fs = fs; t.ls = ls; t.f = f;
        t.exp = {g, e, l, d, b, er, c};
        return t;
    endfunction

    initial begin
        logic [9:0] got, want;
        // reset
        vecs.push_back(mk(1, 0, 0, 0, C_NIL, 0, 0, 0, 0, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 0, 0, C_NIL, 0, 0, 0, 0, 0, 0, 4'd0));
        // 4 digits eq,eq,gt,lt -> gt
        vecs.push_back(mk(0, 1, 1, 0, C_EQ, 0, 0, 0, 0, 1, 0, 4'd1));
        vecs.push_back(mk(0, 1, 0, 0, C_EQ, 0, 0, 0, 0, 1, 0, 4'd2));
        vecs.push_back(mk(0, 1, 0, 0, C_GT, 0, 0, 0, 0, 1, 0, 4'd3));
        vecs.push_back(mk(0, 1, 0, 1, C_LT, 1, 0, 0, 1, 0, 0, 4'd4));
        vecs.push_back(mk(0, 0, 0, 0, C_NIL, 1, 0, 0, 0, 0, 0, 4'd4));
        // 3 digits all equal, held through idle cycles
        vecs.push_back(mk(0, 1, 1, 0, C_EQ, 0, 0, 0, 0, 1, 0, 4'd1));
        vecs.push_back(mk(0, 1, 0, 0, C_EQ, 0, 0, 0, 0, 1, 0, 4'd2));
        vecs.push_back(mk(0, 1, 0, 1, C_EQ, 0, 1, 0, 1, 0, 0, 4'd3));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 0, 0, C_NIL, 0, 1, 0, 0, 0, 0, 4'd3));
        // digit without first while DONE is ignored
        vecs.push_back(mk(0, 1, 0, 0, C_GT, 0, 1, 0, 0, 0, 0, 4'd3));
        // new first with lt clears eq, busy next cycle
        vecs.push_back(mk(0, 1, 1, 0, C_LT, 0, 0, 0, 0, 1, 0, 4'd1));
        vecs.push_back(mk(0, 1, 0, 1, C_EQ, 0, 0, 1, 1, 0, 0, 4'd2));
        // back-to-back single-digit compare in the cycle DONE was entered
        vecs.push_back(mk(0, 1, 1, 1, C_LT, 0, 0, 1, 1, 0, 0, 4'd1));
        vecs.push_back(mk(0, 0, 0, 0, C_NIL, 0, 0, 1, 0, 0, 0, 4'd1));
        // malformed digit 2, stall, locked lt ignores later gt
        vecs.push_back(mk(0, 1, 1, 0, C_EQ, 0, 0, 0, 0, 1, 0, 4'd1));
        vecs.push_back(mk(0, 1, 0, 0, C_BAD, 0, 0, 0, 0, 1, 1, 4'd2));
        vecs.push_back(mk(0, 1, 0, 0, C_LT, 0, 0, 0, 0, 1, 1, 4'd3));
        vecs.push_back(mk(0, 0, 0, 0, C_GT, 0, 0, 0, 0, 1, 1, 4'd3));
        vecs.push_back(mk(0, 1, 0, 1, C_GT, 0, 0, 1, 1, 0, 1, 4'd4));
        // next first clears err; all-zero code on last counts as equal
        vecs.push_back(mk(0, 1, 1, 0, C_EQ, 0, 0, 0, 0, 1, 0, 4'd1));
        vecs.push_back(mk(0, 1, 0, 1, C_NIL, 0, 1, 0, 1, 0, 1, 4'd2));
        // abort: first while running restarts silently
        vecs.push_back(mk(0, 1, 1, 0, C_EQ, 0, 0, 0, 0, 1, 0, 4'd1));
        vecs.push_back(mk(0, 1, 0, 0, C_EQ, 0, 0, 0, 0, 1, 0, 4'd2));
        vecs.push_back(mk(0, 1, 1, 0, C_GT, 0, 0, 0, 0, 1, 0, 4'd1));
        vecs.push_back(mk(0, 1, 0, 1, C_LT, 1, 0, 0, 1, 0, 0, 4'd2));
        // overflow: 9 digits with no last
        vecs.push_back(mk(0, 1, 1, 0, C_GT, 0, 0, 0, 0, 1, 0, 4'd1));
        for (int i = 2; i <= 8; i++)
            vecs.push_back(mk(0, 1, 0, 0, C_EQ, 0, 0, 0, 0, 1, 0, 4'(i)));
        vecs.push_back(mk(0, 1, 0, 0, C_EQ, 0, 0, 0, 1, 0, 1, 4'd8));
        vecs.push_back(mk(0, 0, 0, 0, C_NIL, 0, 0, 0, 0, 0, 1, 4'd8));
        // reset mid-comparison, then a stray digit without first
        vecs.push_back(mk(0, 1, 1, 0, C_EQ, 0, 0, 0, 0, 1, 0, 4'd1));
        vecs.push_back(mk(0, 1, 0, 0, C_EQ, 0, 0, 0, 0, 1, 0, 4'd2));
        vecs.push_back(mk(1, 1, 0, 0, C_GT, 0, 0, 0, 0, 0, 0, 4'd0));
        vecs.push_back(mk(0, 1, 0, 1, C_LT, 0, 0, 0, 0, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 0, 0, C_NIL, 0, 0, 0, 0, 0, 0, 4'd0));

        rst = 1'b1; digit_valid = 1'b0; first = 1'b0; last = 1'b0;
        f1 = 1'b0; f2 = 1'b0; f3 = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst         = vecs[i].rst;
            digit_valid = vecs[i].v;
            first       = vecs[i].fs;
            last        = vecs[i].ls;
            {f1, f2, f3} = vecs[i].f;
            exp_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            got  = {gt, eq, lt, done, busy, err, digit_cnt};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL row%0d {gt,eq,lt,done,busy,err,cnt}: got %b want %b", i, got, want);
            end
        end

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
